// File: rtl/nec_tx_sched.sv
// nec_tx_sched: sits between the NEC IR decoder and the UART transmitter.
// It queues decoded key codes in a small FIFO and converts held-button repeat
// frames into rate-limited re-sends of the last key. The TX FSM sends the FIFO
// contents to the UART one byte at a time.
//
// Optional build macro: NEC_TX_SCHED_ASCII_HEX_EN
//   Defined:   each popped byte is sent as two uppercase ASCII hex digits
//              followed by 0x0A.
//   Undefined: each popped byte is sent raw as a single UART byte.
//
// UART handshake: uart_tx_start is a one-cycle request. uart_tx_data is valid
// from that cycle until uart_tx_busy falls. The UART acknowledges the request
// by raising uart_tx_busy and signals completion by dropping it. A new start
// is issued only while uart_tx_busy is low.
module nec_tx_sched #(
    parameter int CLK_FREQ       = 50_000_000,
    parameter int FIFO_DEPTH     = 8,
    parameter int REPEAT_DIV     = 2,
    parameter int KEY_TIMEOUT_MS = 120
) (
    input  logic                          sys_clk,
    input  logic                          sys_rst_n,
    input  logic [7:0]                    key_data,
    input  logic                          key_en,
    input  logic                          repeat_en,
    input  logic                          uart_tx_busy,
    input  logic                          ovf_clr,
    output logic [7:0]                    uart_tx_data,
    output logic                          uart_tx_start,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_flag
);

    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int LW        = AW + 1;
    localparam int TO_CYCLES = CLK_FREQ / 1000 * KEY_TIMEOUT_MS;
    localparam int TW        = $clog2(TO_CYCLES + 1);
    localparam int RW        = $clog2(REPEAT_DIV + 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_ACK  = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t          state;
    logic [2:0]      key_sync;
    logic [2:0]      rpt_sync;
    logic            key_evt;
    logic            rpt_evt;
    logic            rpt_take;
    logic            push;
    logic            push_ok;
    logic            pop;
    logic            overflow;
    logic            fifo_empty;
    logic            fifo_full;
    logic [7:0]      push_data;
    logic [7:0]      last_key;
    logic            last_valid;
    logic [RW-1:0]   rpt_cnt;
    logic [TW-1:0]   key_tmr;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [1:0]      ack_cnt;
`ifdef NEC_TX_SCHED_ASCII_HEX_EN
    logic [7:0]      cur_byte;
    logic [1:0]      char_idx;

    // Uppercase ASCII hex digit for one nibble.
    function automatic logic [7:0] hex_char(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction
`endif

    // Two-flop synchronisers plus one history flop for rising-edge detection.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_sync <= '0;
            rpt_sync <= '0;
        end else begin
            key_sync <= {key_sync[1:0], key_en};
            rpt_sync <= {rpt_sync[1:0], repeat_en};
        end
    end

    assign key_evt = key_sync[1] & ~key_sync[2];
    assign rpt_evt = rpt_sync[1] & ~rpt_sync[2];

    // Choose what, if anything, is pushed. A key event takes priority over a
    // repeat event in the same cycle.
    always_comb begin
        rpt_take  = rpt_evt & ~key_evt & last_valid;
        push      = 1'b0;
        push_data = key_data;
        if (key_evt) begin
            push = 1'b1;
        end else if (rpt_take && rpt_cnt == RW'(REPEAT_DIV - 1)) begin
            push      = 1'b1;
            push_data = last_key;
        end
    end

    // Last-key tracking, repeat divider, and validity timeout.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            last_key   <= '0;
            last_valid <= 1'b0;
            rpt_cnt    <= '0;
            key_tmr    <= '0;
        end else if (key_evt) begin
            last_key   <= key_data;
            last_valid <= 1'b1;
            rpt_cnt    <= '0;
            key_tmr    <= TW'(TO_CYCLES);
        end else if (rpt_take) begin
            key_tmr <= TW'(TO_CYCLES);
            if (rpt_cnt == RW'(REPEAT_DIV - 1))
                rpt_cnt <= '0;
            else
                rpt_cnt <= rpt_cnt + RW'(1);
        end else if (key_tmr != '0) begin
            key_tmr <= key_tmr - TW'(1);
            if (key_tmr == TW'(1)) begin
                last_valid <= 1'b0;
                rpt_cnt    <= '0;
            end
        end
    end

    assign fifo_empty = (fifo_level == '0);
    assign fifo_full  = (fifo_level == LW'(FIFO_DEPTH));
    assign pop        = (state == S_IDLE) && !fifo_empty && !uart_tx_busy;
    assign push_ok    = push && (!fifo_full || pop);
    assign overflow   = push && fifo_full && !pop;

    // FIFO storage. When the FIFO is full, a push is accepted only together
    // with a pop of the same slot. The pop reads the old value on that edge.
    always_ff @(posedge sys_clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy, and the sticky overflow flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ovf_flag   <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                fifo_level <= fifo_level + LW'(1);
            else if (pop && !push_ok)
                fifo_level <= fifo_level - LW'(1);
            if (overflow)
                ovf_flag <= 1'b1;
            else if (ovf_clr)
                ovf_flag <= 1'b0;
        end
    end

    // TX sequencer. uart_tx_start is registered and is high only in S_START.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state         <= S_IDLE;
            uart_tx_data  <= '0;
            uart_tx_start <= 1'b0;
            ack_cnt       <= '0;
`ifdef NEC_TX_SCHED_ASCII_HEX_EN
            cur_byte      <= '0;
            char_idx      <= '0;
`endif
        end else begin
            uart_tx_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
`ifdef NEC_TX_SCHED_ASCII_HEX_EN
                        cur_byte     <= mem[rd_ptr];
                        char_idx     <= '0;
                        uart_tx_data <= hex_char(mem[rd_ptr][7:4]);
`else
                        uart_tx_data <= mem[rd_ptr];
`endif
                        uart_tx_start <= 1'b1;
                        state         <= S_START;
                    end
                end
                S_START: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    // If the UART does not acknowledge within four cycles,
                    // the byte is dropped.
                    if (uart_tx_busy)
                        state <= S_WAIT_DONE;
                    else if (ack_cnt == 2'd3)
                        state <= S_IDLE;
                    else
                        ack_cnt <= ack_cnt + 2'd1;
                end
                S_WAIT_DONE: begin
                    if (!uart_tx_busy) begin
`ifdef NEC_TX_SCHED_ASCII_HEX_EN
                        if (char_idx == 2'd2) begin
                            state <= S_IDLE;
                        end else begin
                            char_idx      <= char_idx + 2'd1;
                            uart_tx_data  <= (char_idx == 2'd0) ? hex_char(cur_byte[3:0]) : 8'h0A;
                            uart_tx_start <= 1'b1;
                            state         <= S_START;
                        end
`else
                        state <= S_IDLE;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
